// File: rtl/inv_mix_columns_seq_if.sv
// inv_mix_columns_seq_if: valid/ready bundle carrying one 128-bit AES state in and out
interface inv_mix_columns_seq_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;
    logic         busy;
    modport master (output in_valid, state_in, out_ready, input in_ready, out_valid, state_out, busy);
    modport slave  (input in_valid, state_in, out_ready, output in_ready, out_valid, state_out, busy);
endinterface

// File: rtl/inv_mix_columns_seq.sv
// inv_mix_columns_seq: iterative AES InvMixColumns, COLS_PER_CYCLE columns per clock in place
// Columns are visited from bits [127:96] downwards; the result is held until downstream takes it.
module inv_mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input logic                  clk,
    input logic                  rst_n,
    inv_mix_columns_seq_if.slave bus
);
    localparam int NCYC = 4 / COLS_PER_CYCLE;
    localparam logic [1:0] LAST = 2'(NCYC - 1);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t       state, state_nx;
    logic [1:0]   cnt, cnt_nx;
    logic [127:0] data, data_nx, mixed;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_col(input logic [31:0] col);
        logic [7:0] a, x2, x4, x8;
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int i = 0; i < 4; i++) begin
            a     = col[31-8*i -: 8];
            x2    = xt(a);
            x4    = xt(x2);
            x8    = xt(x4);
            m9[i] = x8 ^ a;
            mb[i] = x8 ^ x2 ^ a;
            md[i] = x8 ^ x4 ^ a;
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    // column i is rewritten in the BUSY cycle whose count selects its group, top group first
    for (genvar i = 0; i < 4; i++) begin : g_col
        localparam logic [1:0] SLOT = 2'(NCYC - 1 - i / COLS_PER_CYCLE);
        assign mixed[i*32 +: 32] = (cnt == SLOT) ? inv_col(data[i*32 +: 32]) : data[i*32 +: 32];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            data  <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            data  <= data_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        data_nx  = data;
        case (state)
            IDLE: if (bus.in_valid) begin
                state_nx = BUSY;
                cnt_nx   = '0;
                data_nx  = bus.state_in;
            end
            BUSY: begin
                state_nx = (cnt == LAST) ? DONE : BUSY;
                cnt_nx   = cnt + 2'd1;
                data_nx  = mixed;
            end
            DONE: state_nx = bus.out_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.busy      = (state == BUSY);
    assign bus.out_valid = (state == DONE);
    assign bus.state_out = data;
endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// tb_inv_mix_columns_seq: three instances (1, 2, 4 columns per cycle) checked every cycle
// against a GF(2^8) matrix model and a forward-MixColumns round trip.
module tb_inv_mix_columns_seq;
    localparam logic [127:0] V1 = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
    localparam logic [127:0] E1 = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
    localparam logic [127:0] V2 = 128'h01234567_89abcdef_fedcba98_76543210;
    localparam int N_RT = 400;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n     [3];
    logic         in_valid  [3];
    logic         out_ready [3];
    logic [127:0] state_in  [3];
    logic         in_ready  [3];
    logic         out_valid [3];
    logic         busy      [3];
    logic [127:0] state_out [3];

    for (genvar g = 0; g < 3; g++) begin : g_lane
        inv_mix_columns_seq_if bus ();
        assign bus.in_valid  = in_valid[g];
        assign bus.state_in  = state_in[g];
        assign bus.out_ready = out_ready[g];
        assign in_ready[g]   = bus.in_ready;
        assign out_valid[g]  = bus.out_valid;
        assign busy[g]       = bus.busy;
        assign state_out[g]  = bus.state_out;
        inv_mix_columns_seq #(.COLS_PER_CYCLE(1 << g)) u_dut (
            .clk   (clk),
            .rst_n (rst_n[g]),
            .bus   (bus.slave)
        );
    end

    int checks = 0;
    int failures = 0;
    int cycle = 0;
    logic [127:0] exp_q [3][$];
    logic [127:0] exp_cur [3];
    logic [127:0] prev_out [3];
    logic         prev_valid [3];
    logic         stall [3];
    logic         accd [3];
    int           acc_t [3];
    int           n_out [3];
    int           base [3];
    int           sent [3];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // circulant matrix product; cf holds row 0 coefficients, left to right
    function automatic logic [127:0] mix(input logic [127:0] s, input logic [31:0] cf);
        logic [127:0] r;
        logic [7:0]   acc;
        r = '0;
        for (int c = 0; c < 4; c++)
            for (int j = 0; j < 4; j++) begin
                acc = 8'h00;
                for (int i = 0; i < 4; i++)
                    acc ^= gmul(cf[31-8*((i-j)&3) -: 8], s[c*32+24-8*i +: 8]);
                r[c*32+24-8*j +: 8] = acc;
            end
        return r;
    endfunction

    function automatic logic [127:0] imc(input logic [127:0] s);
        return mix(s, 32'h0e0b0d09);
    endfunction

    function automatic logic [127:0] fmc(input logic [127:0] s);
        return mix(s, 32'h02030101);
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic score();
        for (int l = 0; l < 3; l++) begin
            accd[l] = 1'b0;
            if (!rst_n[l]) begin
                exp_q[l].delete();
                chk1($sformatf("lane%0d_rst_in_ready", l), in_ready[l], 1'b1);
                chk1($sformatf("lane%0d_rst_out_valid", l), out_valid[l], 1'b0);
                chk1($sformatf("lane%0d_rst_busy", l), busy[l], 1'b0);
                chk($sformatf("lane%0d_rst_state_out", l), state_out[l], '0);
                stall[l] = 1'b0;
                prev_valid[l] = 1'b0;
            end else begin
                chk1($sformatf("lane%0d_one_state", l), $onehot({in_ready[l], busy[l], out_valid[l]}), 1'b1);
                if (stall[l]) begin
                    chk1($sformatf("lane%0d_hold_valid", l), out_valid[l], 1'b1);
                    chk($sformatf("lane%0d_hold_data", l), state_out[l], prev_out[l]);
                end
                if (out_valid[l] && !prev_valid[l])
                    chk($sformatf("lane%0d_latency", l), 128'(cycle - acc_t[l]), 128'(4 >> l));
                if (out_valid[l] && out_ready[l]) begin
                    chk1($sformatf("lane%0d_no_duplicate", l), exp_q[l].size() != 0, 1'b1);
                    if (exp_q[l].size() != 0)
                        chk($sformatf("lane%0d_result", l), state_out[l], exp_q[l].pop_front());
                    n_out[l]++;
                end
                if (in_valid[l] && in_ready[l]) begin
                    exp_q[l].push_back(exp_cur[l]);
                    acc_t[l] = cycle + 1;
                    accd[l] = 1'b1;
                end
                stall[l] = out_valid[l] && !out_ready[l];
                prev_out[l] = state_out[l];
                prev_valid[l] = out_valid[l];
            end
        end
        cycle++;
    endtask

    task automatic tick();
        #1;
        score();
        @(negedge clk);
    endtask

    task automatic send(input int l, input logic [127:0] d, input logic [127:0] e);
        state_in[l] = d;
        exp_cur[l] = e;
        in_valid[l] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (accd[l]) break;
        end
        chk1($sformatf("lane%0d_accept", l), accd[l], 1'b1);
        in_valid[l] = 1'b0;
    endtask

    task automatic wait_done(input int l);
        for (int i = 0; i < 20 && !out_valid[l]; i++) tick();
        chk1($sformatf("lane%0d_done_in_time", l), out_valid[l], 1'b1);
    endtask

    task automatic run(input int l, input logic [127:0] d, input logic [127:0] e);
        send(l, d, e);
        wait_done(l);
        chk($sformatf("lane%0d_direct", l), state_out[l], e);
        tick();
    endtask

    initial begin
        logic [127:0] orig;
        int done_lanes;
        for (int l = 0; l < 3; l++) begin
            rst_n[l] = 1'b1;
            in_valid[l] = 1'b0;
            out_ready[l] = 1'b0;
            state_in[l] = '0;
            exp_cur[l] = '0;
            prev_out[l] = '0;
            prev_valid[l] = 1'b0;
            stall[l] = 1'b0;
            accd[l] = 1'b0;
            acc_t[l] = 0;
            n_out[l] = 0;
        end
        orig = {$urandom, $urandom, $urandom, $urandom};
        chk("model_inv_v1", imc(V1), E1);
        chk("model_fwd_e1", fmc(E1), V1);
        chk("model_zero", imc('0), '0);
        chk("model_ones", imc('1), '1);
        chk("model_round_trip", imc(fmc(orig)), orig);

        @(negedge clk);
        for (int l = 0; l < 3; l++) rst_n[l] = 1'b0;
        tick();
        tick();
        for (int l = 0; l < 3; l++) rst_n[l] = 1'b1;
        tick();

        for (int l = 0; l < 3; l++) begin
            out_ready[l] = 1'b1;
            run(l, V1, E1);
            run(l, '0, '0);
            run(l, '1, '1);
        end

        out_ready[0] = 1'b0;
        send(0, V1, E1);
        wait_done(0);
        state_in[0] = V2;
        exp_cur[0] = imc(V2);
        in_valid[0] = 1'b1;
        repeat (10) begin
            tick();
            chk1("bp_in_ready", in_ready[0], 1'b0);
            chk1("bp_out_valid", out_valid[0], 1'b1);
            chk("bp_state_out", state_out[0], E1);
        end
        out_ready[0] = 1'b1;
        tick();
        chk1("release_in_ready", in_ready[0], 1'b1);
        chk1("release_out_valid", out_valid[0], 1'b0);
        run(0, V2, imc(V2));

        send(0, V1, E1);
        tick();
        chk1("busy_before_reset", busy[0], 1'b1);
        rst_n[0] = 1'b0;
        tick();
        chk("mid_reset_state_out", state_out[0], '0);
        tick();
        rst_n[0] = 1'b1;
        tick();
        run(0, V1, E1);

        for (int l = 0; l < 3; l++) begin
            in_valid[l] = 1'b0;
            accd[l] = 1'b0;
            base[l] = n_out[l];
            sent[l] = 0;
        end
        for (int c = 0; c < 60000; c++) begin
            done_lanes = 0;
            for (int l = 0; l < 3; l++) begin
                if (n_out[l] - base[l] == N_RT) done_lanes++;
                if (!in_valid[l] || accd[l]) begin
                    if (sent[l] < N_RT && $urandom_range(1, 0) == 1) begin
                        orig = {$urandom, $urandom, $urandom, $urandom};
                        state_in[l] = fmc(orig);
                        exp_cur[l] = orig;
                        in_valid[l] = 1'b1;
                        sent[l]++;
                    end else begin
                        in_valid[l] = 1'b0;
                    end
                end
                out_ready[l] = ($urandom_range(1, 0) == 1);
            end
            if (done_lanes == 3) break;
            tick();
        end
        for (int l = 0; l < 3; l++) begin
            chk($sformatf("lane%0d_rt_count", l), 128'(n_out[l] - base[l]), 128'(N_RT));
            chk($sformatf("lane%0d_rt_drained", l), 128'(exp_q[l].size()), 128'(0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
